// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike register file and scoreboard.
// Optional read bypass is selected with RISC_V_MIKE_RF_BYPASS_EN (see top).
package risc_v_mike_pkg;

  localparam int unsigned DATA_32_W       = 32;
  localparam int unsigned REGISTER_ADDR_W = 5;
  localparam int unsigned RF_NUM_WR_PORTS = 2;
  localparam int unsigned RF_ZERO_REG     = 0;

  typedef logic [REGISTER_ADDR_W-1:0] t_register_addr;

  typedef struct packed {
    logic                 en;
    t_register_addr       addr;
    logic [DATA_32_W-1:0] data;
  } t_rf_wr_req;

  // True for addresses that map onto a real, writable register.
  function automatic logic f_rf_addr_ok(input int unsigned addr, input int unsigned depth);
    return (addr != RF_ZERO_REG) && (addr < depth);
  endfunction

endpackage

// File: rtl/risc_v_mike_rf_scoreboard.sv
// Per-register pending bits for outstanding load writebacks, plus pending_any.
// With RISC_V_MIKE_RF_BYPASS_EN a same-cycle load writeback clears the read-side pending.
module risc_v_mike_rf_scoreboard
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned REG_FILE_DEPTH = 32,
  parameter int unsigned NUM_RD_PORTS   = 2,
  parameter int unsigned ADDR_W         = 5
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_set_en,
  input  logic [ADDR_W-1:0]                    i_set_addr,
  input  logic                                 i_clr_en,
  input  logic [ADDR_W-1:0]                    i_clr_addr,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]  i_rd_addr,
  output logic [NUM_RD_PORTS-1:0]              o_rd_pending,
  output logic                                 o_pending_any
);

  logic [REG_FILE_DEPTH-1:0] r_pend;
  logic [REG_FILE_DEPTH-1:0] w_pend_next;
  logic                      r_pending_any;
  logic                      w_set_ok;
  logic                      w_clr_ok;
  logic [NUM_RD_PORTS-1:0]   w_rd_ok;

  assign w_set_ok = i_set_en && f_rf_addr_ok(32'(i_set_addr), REG_FILE_DEPTH);
  assign w_clr_ok = i_clr_en && f_rf_addr_ok(32'(i_clr_addr), REG_FILE_DEPTH);

  // Clear first so a reserve issued in the same cycle wins.
  always_comb begin
    w_pend_next = r_pend;
    if (w_clr_ok) w_pend_next[i_clr_addr] = 1'b0;
    if (w_set_ok) w_pend_next[i_set_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend        <= '0;
      r_pending_any <= 1'b0;
    end else begin
      r_pend        <= w_pend_next;
      r_pending_any <= |w_pend_next;
    end
  end

  assign o_pending_any = r_pending_any;

  always_comb begin
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      w_rd_ok[p]      = f_rf_addr_ok(32'(i_rd_addr[p]), REG_FILE_DEPTH);
      o_rd_pending[p] = 1'b0;
      if (w_rd_ok[p]) o_rd_pending[p] = r_pend[i_rd_addr[p]];
`ifdef RISC_V_MIKE_RF_BYPASS_EN
      if (w_rd_ok[p] && w_clr_ok && (i_clr_addr == i_rd_addr[p]) &&
          !(w_set_ok && (i_set_addr == i_rd_addr[p])))
        o_rd_pending[p] = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/risc_v_mike_reg_file_sb.sv
// Multi-read, dual-write register file with load-pending scoreboard; x0 reads as zero.
// Define RISC_V_MIKE_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module risc_v_mike_reg_file_sb
  import risc_v_mike_pkg::*;
#(
  parameter  int unsigned REG_FILE_WIDTH = 32,
  parameter  int unsigned REG_FILE_DEPTH = 32,
  parameter  int unsigned NUM_RD_PORTS   = 2,
  localparam int unsigned ADDR_W         = $clog2(REG_FILE_DEPTH)
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]         i_rd_addr,
  output logic [NUM_RD_PORTS-1:0][REG_FILE_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD_PORTS-1:0]                     o_rd_pending,
  input  logic                                        i_wr0_en,
  input  logic [ADDR_W-1:0]                           i_wr0_addr,
  input  logic [REG_FILE_WIDTH-1:0]                   i_wr0_data,
  input  logic                                        i_wr1_en,
  input  logic [ADDR_W-1:0]                           i_wr1_addr,
  input  logic [REG_FILE_WIDTH-1:0]                   i_wr1_data,
  input  logic                                        i_rsv_en,
  input  logic [ADDR_W-1:0]                           i_rsv_addr,
  output logic                                        o_pending_any
);

  logic [REG_FILE_WIDTH-1:0] r_mem [REG_FILE_DEPTH];
  logic                      w_wr0_ok;
  logic                      w_wr1_ok;
  logic [NUM_RD_PORTS-1:0]   w_rd_ok;

  assign w_wr0_ok = i_wr0_en && f_rf_addr_ok(32'(i_wr0_addr), REG_FILE_DEPTH);
  assign w_wr1_ok = i_wr1_en && f_rf_addr_ok(32'(i_wr1_addr), REG_FILE_DEPTH);

  // Load writeback wins a same-address collision; the ALU write is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(REG_FILE_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_wr0_ok && !(w_wr1_ok && (i_wr1_addr == i_wr0_addr)))
        r_mem[i_wr0_addr] <= i_wr0_data;
      if (w_wr1_ok)
        r_mem[i_wr1_addr] <= i_wr1_data;
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      w_rd_ok[p]   = f_rf_addr_ok(32'(i_rd_addr[p]), REG_FILE_DEPTH);
      o_rd_data[p] = '0;
      if (w_rd_ok[p]) o_rd_data[p] = r_mem[i_rd_addr[p]];
`ifdef RISC_V_MIKE_RF_BYPASS_EN
      if (w_rd_ok[p] && w_wr1_ok && (i_wr1_addr == i_rd_addr[p]))
        o_rd_data[p] = i_wr1_data;
      else if (w_rd_ok[p] && w_wr0_ok && (i_wr0_addr == i_rd_addr[p]))
        o_rd_data[p] = i_wr0_data;
`endif
    end
  end

  risc_v_mike_rf_scoreboard #(
    .REG_FILE_DEPTH (REG_FILE_DEPTH),
    .NUM_RD_PORTS   (NUM_RD_PORTS),
    .ADDR_W         (ADDR_W)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_set_en      (i_rsv_en),
    .i_set_addr    (i_rsv_addr),
    .i_clr_en      (i_wr1_en),
    .i_clr_addr    (i_wr1_addr),
    .i_rd_addr     (i_rd_addr),
    .o_rd_pending  (o_rd_pending),
    .o_pending_any (o_pending_any)
  );

endmodule

// File: tb/tb_risc_v_mike_reg_file_sb.sv
// Scoreboard bench for risc_v_mike_reg_file_sb (depth 20, two read ports).
// Honours RISC_V_MIKE_RF_BYPASS_EN in its reference model.
module tb_risc_v_mike_reg_file_sb;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 20;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N-1:0][AW-1:0]     rd_addr = '0;
  logic [N-1:0][W-1:0]      rd_data;
  logic [N-1:0]             rd_pending;
  logic                     wr0_en = 1'b0;
  logic [AW-1:0]            wr0_addr = '0;
  logic [W-1:0]             wr0_data = '0;
  logic                     wr1_en = 1'b0;
  logic [AW-1:0]            wr1_addr = '0;
  logic [W-1:0]             wr1_data = '0;
  logic                     rsv_en = 1'b0;
  logic [AW-1:0]            rsv_addr = '0;
  logic                     pending_any;

  risc_v_mike_reg_file_sb #(
    .REG_FILE_WIDTH (W),
    .REG_FILE_DEPTH (D),
    .NUM_RD_PORTS   (N)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_pending  (rd_pending),
    .i_wr0_en      (wr0_en),
    .i_wr0_addr    (wr0_addr),
    .i_wr0_data    (wr0_data),
    .i_wr1_en      (wr1_en),
    .i_wr1_addr    (wr1_addr),
    .i_wr1_data    (wr1_data),
    .i_rsv_en      (rsv_en),
    .i_rsv_addr    (rsv_addr),
    .o_pending_any (pending_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  id;
    logic [N-1:0][W-1:0] data;
    logic [N-1:0]        pend;
    logic                pany;
  } exp_t;

  exp_t       q[$];
  logic [W-1:0] m_mem [32];
  bit         m_pend [32];
  bit         m_pany;
  int         checks = 0;
  int         errors = 0;
  int         step_id = 0;

  function automatic bit ok(input int a);
    return (a != 0) && (a < int'(D));
  endfunction

  // Architectural effect of one clock edge given the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr0_en && ok(int'(wr0_addr))) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && ok(int'(wr1_addr))) begin
        m_mem[wr1_addr]  = wr1_data;
        m_pend[wr1_addr] = 1'b0;
      end
      if (rsv_en && ok(int'(rsv_addr))) m_pend[rsv_addr] = 1'b1;
    end
    m_pany = 1'b0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) m_pany = 1'b1;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.id   = step_id;
    e.pany = m_pany;
    for (int p = 0; p < int'(N); p++) begin
      int a;
      a = int'(rd_addr[p]);
      e.data[p] = ok(a) ? m_mem[a] : '0;
      e.pend[p] = ok(a) ? m_pend[a] : 1'b0;
`ifdef RISC_V_MIKE_RF_BYPASS_EN
      if (ok(a) && wr1_en && int'(wr1_addr) == a) begin
        e.data[p] = wr1_data;
        if (!(rsv_en && int'(rsv_addr) == a)) e.pend[p] = 1'b0;
      end else if (ok(a) && wr0_en && int'(wr0_addr) == a) begin
        e.data[p] = wr0_data;
      end
`endif
    end
    return e;
  endfunction

  task automatic step(input bit r,
                      input bit w0e, input int w0a, input logic [W-1:0] w0d,
                      input bit w1e, input int w1a, input logic [W-1:0] w1d,
                      input bit re, input int ra, input int a0, input int a1);
    @(posedge clk);
    model_edge();
    #1;
    rst        = r;
    wr0_en     = w0e;  wr0_addr = AW'(w0a);  wr0_data = w0d;
    wr1_en     = w1e;  wr1_addr = AW'(w1a);  wr1_data = w1d;
    rsv_en     = re;   rsv_addr = AW'(ra);
    rd_addr[0] = AW'(a0);
    rd_addr[1] = AW'(a1);
    step_id++;
    q.push_back(expect_now());
  endtask

  task automatic rd(input int a0, input int a1);
    step(0, 0, 0, '0, 0, 0, '0, 0, 0, a0, a1);
  endtask

  task automatic chk(input string nm, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", nm, id, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rd_data0", e.id, rd_data[0], e.data[0]);
        chk("rd_data1", e.id, rd_data[1], e.data[1]);
        chk("rd_pend0", e.id, W'(rd_pending[0]), W'(e.pend[0]));
        chk("rd_pend1", e.id, W'(rd_pending[1]), W'(e.pend[1]));
        chk("pend_any", e.id, W'(pending_any), W'(e.pany));
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_pany = 1'b0;

    step(1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    step(1, 1, 5, 32'h1234, 1, 6, 32'h5678, 1, 6, 5, 6);
    step(0, 0, 0, '0, 0, 0, '0, 0, 0, 5, 6);
    for (int a = 0; a < 32; a++) rd(a, 31 - a);

    step(0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 5, 0);
    rd(5, 4);

    step(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5);
    rd(7, 7);

    step(0, 0, 0, '0, 0, 0, '0, 1, 9, 9, 8);
    rd(9, 10);
    step(0, 0, 0, '0, 1, 9, 32'h55, 0, 0, 9, 7);
    rd(9, 9);
    step(0, 0, 0, '0, 1, 9, 32'h66, 1, 9, 9, 5);
    rd(9, 0);
    step(0, 0, 0, '0, 1, 9, 32'h67, 0, 0, 9, 9);
    rd(9, 9);

    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, '0, 1, 0, 0, 5);
    rd(0, 0);

    step(0, 1, 25, 32'hAA, 1, 21, 32'hBB, 1, 25, 25, 21);
    rd(25, 21);
    for (int a = 0; a < 32; a++) rd(a, (a + 7) % 32);

    step(0, 0, 0, '0, 0, 0, '0, 1, 3, 3, 0);
    rd(3, 0);
    step(1, 0, 0, '0, 0, 0, '0, 0, 0, 3, 9);
    rd(3, 9);
    step(0, 0, 0, '0, 1, 3, 32'h77, 0, 0, 3, 0);
    rd(3, 3);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(39, 0) == 0,
           1'($urandom_range(1, 0)), $urandom_range(23, 0), $urandom,
           1'($urandom_range(1, 0)), $urandom_range(23, 0), $urandom,
           1'($urandom_range(1, 0)), $urandom_range(23, 0),
           $urandom_range(23, 0), $urandom_range(31, 0));
    end
    for (int a = 0; a < 32; a++) rd(a, 31 - a);

    for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_v_mike_reg_file_sb.md
# risc_v_mike_reg_file_sb

Parametrised integer register file with N read ports, two write ports and a per-register pending scoreboard. Replaces the single-write, two-read register file in the decode/writeback stages. Port 0 takes ALU writeback; port 1 takes long-latency load writeback. Long-latency loads reserve their destination at issue so that hazard logic can stall on `rd_pending`.

## Interface
- `REG_FILE_WIDTH`, 32, data width in bits.
- `REG_FILE_DEPTH`, 32, number of architectural registers; register 0 is hardwired to zero.
- `NUM_RD_PORTS`, 2, number of independent read ports (1..4).
- `ADDR_W`, `$clog2(REG_FILE_DEPTH)`, address width (localparam).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_addr`  in  `NUM_RD_PORTS`×`ADDR_W`  read addresses.
- `rd_data`  out  `NUM_RD_PORTS`×`REG_FILE_WIDTH`  read data, combinational.
- `rd_pending`  out  `NUM_RD_PORTS`  addressed register awaits a load writeback.
- `wr0_en` / `wr0_addr` / `wr0_data`  in  1 / `ADDR_W` / `REG_FILE_WIDTH`  ALU write port.
- `wr1_en` / `wr1_addr` / `wr1_data`  in  1 / `ADDR_W` / `REG_FILE_WIDTH`  load write port; clears pending.
- `rsv_en` / `rsv_addr`  in  1 / `ADDR_W`  reserve (set pending) at load issue.
- `pending_any`  out  1  OR of all pending bits, registered.

## Operation
- Storage: `REG_FILE_DEPTH` registers of `REG_FILE_WIDTH` bits plus `REG_FILE_DEPTH` pending bits, all flops.
- Write: on a `clk` edge with `wrX_en`=1, `mem[wrX_addr]` ← `wrX_data`.
- Same-address dual write: port 1 (load) wins and port 0 is dropped.
- Pending set: at the edge with `rsv_en`=1, `pend[rsv_addr]` ← 1.
- Pending clear: at the edge with `wr1_en`=1, `pend[wr1_addr]` ← 0. `wr0` never changes pending.
- Simultaneous reserve and clear of the same address: set wins, because a new load was issued.
- Reserve of an already pending register: it stays pending. No counting; one outstanding load per destination.
- Register 0:
  - writes and reserves to it are ignored;
  - reads return 0 with pending 0.
- Addresses ≥ `REG_FILE_DEPTH` (non-power-of-two depth):
  - writes and reserves are ignored;
  - reads return 0 with pending 0.
- Reads are combinational from storage, subject to bypass (see Configuration).

## Timing
- Reset: all data registers 0, all pending bits 0, `pending_any`=0 at the first edge with `rst`=1.
- Reset has priority over every same-cycle write or reserve.
- Reset mid-operation discards outstanding reservations. A later `wr1` to that address still writes data and leaves pending at 0.
- Outputs under reset: `rd_data`=0 and `rd_pending`=0 on every port, because storage is 0.
- Write-to-storage latency: 1 cycle. The value is visible from storage on the cycle after the enable edge.
- `rsv_en` → `rd_pending`=1: visible the cycle after the reserve. A same-cycle read does not see it.
- `pending_any`: reflects the pending state after the edge, with 1-cycle latency from a set or clear.

## Configuration
- Macro: `RISC_V_MIKE_RF_BYPASS_EN`.
- Defined:
  - a read whose address matches an active same-cycle write returns the write data, with `wr1` taking priority over `wr0`;
  - a read matching a same-cycle `wr1` reports `rd_pending`=0, unless a same-cycle `rsv` targets that address;
  - register 0 is still forced to 0.
- Undefined:
  - reads see storage only, so a write becomes visible 1 cycle later;
  - `rd_pending` reflects stored pending bits only.

## Structure
- `risc_v_mike_pkg` gains:
  - `RF_NUM_WR_PORTS` = 2;
  - `RF_ZERO_REG` = 0;
  - `typedef struct packed { logic en; t_register_addr addr; logic [DATA_32_W-1:0] data; } t_rf_wr_req`.
- `t_register_addr` is reused for all address ports. `DATA_32_W` must equal the default `REG_FILE_WIDTH`.
- Sub-module `risc_v_mike_rf_scoreboard` holds the pending bits, set/clear priority, the zero/out-of-range masking and `pending_any`.
- Data storage, write-port arbitration and read/bypass muxing live in the top.
- Flops use the existing synchronous reset FF macro.

## Test plan
- Reset, then read all addresses on both ports → `rd_data`=0, `rd_pending`=0, `pending_any`=0.
- `wr0` x5=0xDEADBEEF, then read x5 next cycle → 0xDEADBEEF.
  - Same-cycle read returns 0xDEADBEEF with bypass, 0 without.
- Same cycle: `wr0` x7=0x11, `wr1` x7=0x22 → x7=0x22; the bypassed same-cycle read also returns 0x22.
- `rsv` x9 → `rd_pending`=1 and `pending_any`=1 from the next cycle.
  - `wr1` x9=0x55 → pending 0 and x9=0x55 the following cycle.
  - Same-cycle `rsv` x9 plus `wr1` x9 → x9 remains pending.
- `wr0` x0=0xFFFFFFFF and `rsv` x0 → x0 reads 0 with pending 0.
  - With `REG_FILE_DEPTH`=20, a write to address 25 → no register changes.
- `rsv` x3, assert `rst` for 1 cycle, then `wr1` x3=0x77 → pending 0 throughout after reset; x3=0x77.
